// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W_DEF     = 64;
  localparam int DATA_W_DEF     = 64;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants issued while fetch waits; flags when the limit is reached.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != CW'(STARVE_MAX)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign at_max_o = (cnt_q == CW'(STARVE_MAX));
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch and data paths; data has priority.
// Define MEM_ARB_FAIR_EN to bound fetch starvation with mem_arb_starve_ctr.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              we_q, we_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic              i_elig, d_elig, fetch_first;
  logic              grant_i, grant_d;

  // A requester whose done is showing is dropping that request, so it must not win again.
  assign i_elig  = i_req & ~i_done_q;
  assign d_elig  = d_req & ~d_done_q;
  assign grant_i = (state_q == IDLE) && (state_d == GRANT_I);
  assign grant_d = (state_q == IDLE) && (state_d == GRANT_D);

`ifdef MEM_ARB_FAIR_EN
  mem_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc_i    (grant_d & i_elig),
    .clr_i    (~i_req | grant_i),
    .at_max_o (fetch_first)
  );
`else
  assign fetch_first = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_elig && !(i_elig && fetch_first)) state_d = GRANT_D;
        else if (i_elig)                        state_d = GRANT_I;
      end
      GRANT_I, GRANT_D: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_done_d  = 1'b0;
    d_done_d  = 1'b0;
    if (grant_d) begin
      addr_d  = d_addr;
      we_d    = d_we;
      wdata_d = d_wdata;
    end else if (grant_i) begin
      addr_d  = i_addr;
      we_d    = 1'b0;
      wdata_d = '0;
    end
    if (state_q == GRANT_I && mem_ack) begin
      i_rdata_d = mem_rdata;
      i_done_d  = 1'b1;
    end
    // Stores leave the previous load data in place.
    if (state_q == GRANT_D && mem_ack) begin
      d_done_d = 1'b1;
      if (!we_q) d_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_req & ~d_done_q;
endmodule
